// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions: sequencer state encoding, register-index width
// and the control-field widths carried by the pipeline registers.
package pipe_pkg;

    localparam int REG_W     = 5;
    localparam int CTRL_W    = 10;
    localparam int ALUCTRL_W = 2;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_HALT     = 2'd3
    } state_t;

    // Per-cycle enables/bubble controls for the pc, if_id, id_ex and ex_mem registers.
    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic if_id_flush;
        logic id_ex_we;
        logic id_ex_bubble;
        logic ex_mem_we;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_FREEZE = '{default: 1'b0};
    localparam pipe_ctrl_t CTRL_RESET  = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b1,
                                           id_ex_we: 1'b0, id_ex_bubble: 1'b1, ex_mem_we: 1'b0};

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare: the load in EX writes a register the ID instruction reads.
module hazard_detect #(
    parameter int REG_W = pipe_pkg::REG_W
) (
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_id_uses_rt,
    input  logic [REG_W-1:0] i_ex_rt,
    input  logic             i_ex_mem_read,
    output logic             o_load_use
);

    logic w_rs_match;
    logic w_rt_match;

    always_comb begin
        w_rs_match = (i_ex_rt == i_id_rs);
        w_rt_match = i_id_uses_rt && (i_ex_rt == i_id_rt);
        // r0 is hardwired, so a load targeting it never creates a dependency.
        o_load_use = i_ex_mem_read && (i_ex_rt != '0) && (w_rs_match || w_rt_match);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: load-use stall, branch flush and data-memory freeze,
// with memory-timeout halt and a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int REG_W       = pipe_pkg::REG_W,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_we,
    output logic             id_ex_bubble,
    output logic             ex_mem_we,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    import pipe_pkg::*;

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [WAIT_W-1:0]  w_wait_nxt;
    logic               r_halted;
    logic               w_halt_set;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic               w_load_use;
    pipe_ctrl_t         w_run_ctrl;
    pipe_ctrl_t         w_ctrl;

    hazard_detect #(
        .REG_W(REG_W)
    ) u_hazard_detect (
        .i_id_rs      (id_rs),
        .i_id_rt      (id_rt),
        .i_id_uses_rt (id_uses_rt),
        .i_ex_rt      (ex_rt),
        .i_ex_mem_read(ex_mem_read),
        .o_load_use   (w_load_use)
    );

    // Branch/load-use/normal decode, shared by RUN and the MEM_WAIT release cycle.
    always_comb begin
        w_run_ctrl = '{default: 1'b1};
        w_run_ctrl.if_id_flush  = 1'b0;
        w_run_ctrl.id_ex_bubble = 1'b0;
        if (ex_branch_taken) begin
            w_run_ctrl.if_id_flush  = 1'b1;
            w_run_ctrl.id_ex_bubble = 1'b1;
        end else if (w_load_use) begin
            w_run_ctrl.pc_we        = 1'b0;
            w_run_ctrl.if_id_we     = 1'b0;
            w_run_ctrl.id_ex_bubble = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_halt_set  = 1'b0;
        w_ctrl      = CTRL_FREEZE;
        unique case (r_state)
            ST_INIT: begin
                w_ctrl       = CTRL_RESET;
                w_ctrl.pc_we = 1'b1;
                w_state_nxt  = ST_RUN;
            end
            ST_RUN: begin
                if (mem_req && !mem_ready) begin
                    w_state_nxt = ST_MEM_WAIT;
                    w_wait_nxt  = WAIT_W'(1);
                end else begin
                    w_ctrl = w_run_ctrl;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    w_ctrl      = w_run_ctrl;
                    w_state_nxt = ST_RUN;
                    w_wait_nxt  = '0;
                end else if (r_wait_cnt >= WAIT_W'(MEM_TIMEOUT)) begin
                    w_halt_set  = 1'b1;
                    w_state_nxt = ST_HALT;
                    w_wait_nxt  = '0;
                end else begin
                    w_wait_nxt = r_wait_cnt + 1'b1;
                end
            end
            ST_HALT: begin
                w_ctrl = CTRL_FREEZE;
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
        // Outputs follow reset combinationally so the pipe is frozen while reset is held.
        if (!reset_n) begin
            w_ctrl = CTRL_RESET;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_INIT;
            r_wait_cnt  <= '0;
            r_halted    <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_halted   <= r_halted | w_halt_set;
            if ((r_state != ST_INIT) && !w_ctrl.pc_we && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign pc_we        = w_ctrl.pc_we;
    assign if_id_we     = w_ctrl.if_id_we;
    assign if_id_flush  = w_ctrl.if_id_flush;
    assign id_ex_we     = w_ctrl.id_ex_we;
    assign id_ex_bubble = w_ctrl.id_ex_bubble;
    assign ex_mem_we    = w_ctrl.ex_mem_we;
    assign halted       = r_halted;
    assign stall_count  = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed vectors, corner sequences
// and randomized traffic checked against a behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int TO   = 4;
    localparam int CW   = 3;
    localparam int SMAX = (1 << CW) - 1;

    // Control vector order: {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we}
    localparam logic [5:0] C_RST    = 6'b001010;
    localparam logic [5:0] C_INIT   = 6'b101010;
    localparam logic [5:0] C_FREEZE = 6'b000000;
    localparam logic [5:0] C_BRANCH = 6'b111111;
    localparam logic [5:0] C_LU     = 6'b000111;
    localparam logic [5:0] C_NORM   = 6'b110101;
    localparam logic [6:0] NOCHK    = 7'b1000000;

    logic          clock;
    logic          reset_n;
    logic [4:0]    id_rs, id_rt, ex_rt;
    logic          id_uses_rt, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
    logic          pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, halted;
    logic [CW-1:0] stall_count;

    int checks = 0;
    int errors = 0;

    // Model state: first cycle after reset, consecutive memory-wait cycles, halt, stall tally.
    bit m_init;
    int m_wait;
    bit m_halt;
    int m_stall;

    pipeline_hazard_ctrl #(
        .REG_W(5),
        .MEM_TIMEOUT(TO),
        .CNT_W(CW)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rt     (id_uses_rt),
        .ex_rt          (ex_rt),
        .ex_mem_read    (ex_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .pc_we          (pc_we),
        .if_id_we       (if_id_we),
        .if_id_flush    (if_id_flush),
        .id_ex_we       (id_ex_we),
        .id_ex_bubble   (id_ex_bubble),
        .ex_mem_we      (ex_mem_we),
        .halted         (halted),
        .stall_count    (stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [5:0] model_ctrl();
        bit lu;
        if (!reset_n) return C_RST;
        if (m_init) return C_INIT;
        if (m_halt) return C_FREEZE;
        if (!mem_ready && (m_wait > 0 || mem_req)) return C_FREEZE;
        if (ex_branch_taken) return C_BRANCH;
        lu = ex_mem_read && (ex_rt != 0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        if (lu) return C_LU;
        return C_NORM;
    endfunction

    task automatic model_step();
        logic [5:0] c;
        c = model_ctrl();
        if (!reset_n) begin
            m_init = 1; m_wait = 0; m_halt = 0; m_stall = 0;
            return;
        end
        if (!m_init && !c[5] && m_stall < SMAX) m_stall++;
        if (m_init) m_init = 0;
        else if (m_halt) m_halt = 1;
        else if (m_wait > 0) begin
            if (mem_ready) m_wait = 0;
            else if (m_wait >= TO) begin m_halt = 1; m_wait = 0; end
            else m_wait++;
        end else if (mem_req && !mem_ready) m_wait = 1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic compare(input string tag);
        logic [5:0] a;
        a = {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we};
        check({tag, ".ctrl"}, 32'(a), 32'(model_ctrl()));
        check({tag, ".halted"}, 32'(halted), reset_n ? 32'(m_halt) : 32'd0);
        check({tag, ".stall"}, 32'(stall_count), reset_n ? 32'(m_stall) : 32'd0);
    endtask

    // Inputs are already applied (posedge+1); check mid-cycle, then advance the model.
    task automatic cyc(input string tag, input logic [6:0] x = NOCHK);
        #3;
        compare(tag);
        if (!x[6]) check({tag, ".spec"},
                         32'({pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we}),
                         32'(x[5:0]));
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic idle();
        id_rs = '0; id_rt = '0; ex_rt = '0; id_uses_rt = 0; ex_mem_read = 0;
        ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 0;
        cyc("rst", {1'b0, C_RST});
        cyc("rst2", {1'b0, C_RST});
        reset_n = 1;
        cyc("init", {1'b0, C_INIT});
    endtask

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic [4:0] ext;
        logic       ld;
        logic       br;
        logic       req;
        logic [5:0] exp;
    } vec_t;

    vec_t vt[9];

    initial begin
        vt[0] = '{5'd5, 5'd1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, C_LU};
        vt[1] = '{5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, C_NORM};
        vt[2] = '{5'd1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, C_LU};
        vt[3] = '{5'd1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, C_NORM};
        vt[4] = '{5'd9, 5'd2, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, C_NORM};
        vt[5] = '{5'd3, 5'd3, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, C_BRANCH};
        vt[6] = '{5'd4, 5'd6, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0, C_BRANCH};
        vt[7] = '{5'd4, 5'd6, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, C_NORM};
        vt[8] = '{5'd31, 5'd2, 1'b0, 5'd31, 1'b1, 1'b0, 1'b1, C_LU};

        reset_n = 0;
        idle();
        m_init = 1; m_wait = 0; m_halt = 0; m_stall = 0;
        @(posedge clock);
        #1;

        // Reset release: INIT then RUN.
        do_reset();
        cyc("run0", {1'b0, C_NORM});

        // Directed vectors in RUN (mem_req with mem_ready=1 must not stall).
        for (int i = 0; i < 9; i++) begin
            id_rs = vt[i].rs; id_rt = vt[i].rt; id_uses_rt = vt[i].uses_rt;
            ex_rt = vt[i].ext; ex_mem_read = vt[i].ld; ex_branch_taken = vt[i].br;
            mem_req = vt[i].req; mem_ready = vt[i].req;
            cyc($sformatf("vec%0d", i), {1'b0, vt[i].exp});
        end

        // Single load-use bubble counts one stall; r0 load never stalls.
        do_reset();
        ex_mem_read = 1; ex_rt = 5'd5; id_rs = 5'd5;
        cyc("lu", {1'b0, C_LU});
        idle();
        cyc("lu.next", {1'b0, C_NORM});
        check("lu.stall", 32'(stall_count), 32'd1);
        ex_mem_read = 1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1;
        cyc("lu.r0", {1'b0, C_NORM});
        check("lu.r0.stall", 32'(stall_count), 32'd1);

        // Memory wait: three frozen cycles, release on the fourth.
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) cyc($sformatf("mw%0d", i), {1'b0, C_FREEZE});
        mem_ready = 1;
        cyc("mw.rel", {1'b0, C_NORM});
        idle();
        cyc("mw.after", {1'b0, C_NORM});
        check("mw.stall", 32'(stall_count), 32'd3);

        // Branch pending in EX resolves in the release cycle.
        mem_req = 1; mem_ready = 0; ex_branch_taken = 1;
        cyc("mwb.frz", {1'b0, C_FREEZE});
        mem_ready = 1;
        cyc("mwb.rel", {1'b0, C_BRANCH});

        // Timeout: one RUN freeze plus TO wait cycles, then sticky HALT and saturation.
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < TO + 1; i++) cyc($sformatf("to%0d", i), {1'b0, C_FREEZE});
        check("to.halted", 32'(halted), 32'd1);
        mem_ready = 1; ex_branch_taken = 1;
        for (int i = 0; i < 10; i++) cyc($sformatf("halt%0d", i), {1'b0, C_FREEZE});
        check("sat.stall", 32'(stall_count), 32'(SMAX));
        check("halt.sticky", 32'(halted), 32'd1);
        reset_n = 0;
        #1;
        check("rst.halted", 32'(halted), 32'd0);
        check("rst.stall", 32'(stall_count), 32'd0);
        #1;
        cyc("rst.halt", {1'b0, C_RST});
        reset_n = 1;
        cyc("init.halt", {1'b0, C_INIT});

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            id_rs = 5'($urandom_range(0, 3));
            id_rt = 5'($urandom_range(0, 3));
            ex_rt = 5'($urandom_range(0, 3));
            id_uses_rt = 1'($urandom_range(0, 1));
            ex_mem_read = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 4) == 0);
            mem_req = ($urandom_range(0, 2) == 0);
            mem_ready = ($urandom_range(0, 1) == 0);
            reset_n = ($urandom_range(0, 39) != 0);
            cyc($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
